// File: rtl/capture_pkg.sv
// capture_pkg: shared definitions for the logic analyzer capture path.
//   state_t        capture FSM encoding (3 bits)
//   DATA_LEN_DEF   default sample width
//   DEPTH_DEF      default sample SRAM depth
package capture_pkg;

  localparam int DATA_LEN_DEF = 32;
  localparam int DEPTH_DEF    = 1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/trig_match.sv
// trig_match: combinational masked comparator.
//   data_in     sample under test
//   trig_value  value to compare against
//   trig_mask   1 = bit participates in the compare
//   hit         1 when every masked bit of data_in equals trig_value
// An all-zero mask compares nothing and therefore always hits.
module trig_match
  import capture_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic [DATA_LEN-1:0] data_in,
  input  logic [DATA_LEN-1:0] trig_value,
  input  logic [DATA_LEN-1:0] trig_mask,
  output logic                hit
);

  assign hit = ~|((data_in ^ trig_value) & trig_mask);

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: write-side controller of the logic analyzer capture path.
// Drives the sample SRAM write port as a circular buffer holding pre_q
// samples before the trigger, the trigger sample, and DEPTH-1-pre_q after.
//
// Ports:
//   clk         capture clock
//   rst         asynchronous active-high reset
//   arm         one-cycle start request (ignored while busy)
//   abort       one-cycle cancel request (wins over arm)
//   sample_en   data_in is valid this cycle
//   data_in     probe sample
//   trig_value  trigger compare value
//   trig_mask   trigger compare mask (1 = bit compared)
//   pre_len     number of pre-trigger samples, latched on arm
//   wen         SRAM write enable (registered)
//   wr_addr     SRAM write address (registered)
//   wr_data     SRAM write data (registered)
//   busy        capture in progress (PRE, WAIT, POST)
//   triggered   trigger sample has been written
//   done        capture complete, buffer stable
//   trig_addr   address of the trigger sample
//   start_addr  address of the oldest sample, valid with done
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | not capturing; waits for arm
// PRE   | filling pre_q pre-trigger samples, trigger ignored
// WAIT  | writing around the ring until the first trigger hit
// POST  | writing the remaining DEPTH-1-pre_q post-trigger samples
// DONE  | buffer complete; start_addr valid; arm re-arms
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_LEN = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                sample_en,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic [DATA_LEN-1:0] trig_value,
  input  logic [DATA_LEN-1:0] trig_mask,
  input  logic [ADDR_LEN-1:0] pre_len,
  output logic                wen,
  output logic [ADDR_LEN-1:0] wr_addr,
  output logic [DATA_LEN-1:0] wr_data,
  output logic                busy,
  output logic                triggered,
  output logic                done,
  output logic [ADDR_LEN-1:0] trig_addr,
  output logic [ADDR_LEN-1:0] start_addr
);

  localparam logic [ADDR_LEN-1:0] ADDR_MAX = ADDR_LEN'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [ADDR_LEN-1:0] ptr, ptr_nxt;
  logic [ADDR_LEN-1:0] count, count_nxt;
  logic [ADDR_LEN-1:0] pre_q, pre_q_nxt;
  logic [ADDR_LEN-1:0] post_cnt, post_cnt_nxt;
  logic                triggered_nxt;
  logic [ADDR_LEN-1:0] trig_addr_nxt, start_addr_nxt;
  logic                wen_nxt;
  logic [ADDR_LEN-1:0] wr_addr_nxt;
  logic [DATA_LEN-1:0] wr_data_nxt;

  logic                hit;
  logic [ADDR_LEN-1:0] count_inc;
  logic [ADDR_LEN-1:0] post_init;

  trig_match #(
    .DATA_LEN (DATA_LEN)
  ) u_trig_match (
    .data_in    (data_in),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .hit        (hit)
  );

  assign count_inc = count + 1'b1;
  // Samples still owed after the trigger so the ring holds exactly DEPTH.
  assign post_init = ADDR_MAX - pre_q;

  assign busy = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      count      <= '0;
      pre_q      <= '0;
      post_cnt   <= '0;
      triggered  <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
      wen        <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      count      <= count_nxt;
      pre_q      <= pre_q_nxt;
      post_cnt   <= post_cnt_nxt;
      triggered  <= triggered_nxt;
      trig_addr  <= trig_addr_nxt;
      start_addr <= start_addr_nxt;
      wen        <= wen_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    count_nxt      = count;
    pre_q_nxt      = pre_q;
    post_cnt_nxt   = post_cnt;
    triggered_nxt  = triggered;
    trig_addr_nxt  = trig_addr;
    start_addr_nxt = start_addr;
    wen_nxt        = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;

    if (abort) begin
      // The sample presented with abort is dropped; a write already on
      // the port this cycle completes on its own.
      state_nxt     = ST_IDLE;
      triggered_nxt = 1'b0;
    end else begin
      // Every accepted sample in PRE/WAIT/POST is written at ptr; the
      // pointer wraps naturally because DEPTH is a power of two.
      if (busy && sample_en) begin
        wen_nxt     = 1'b1;
        wr_addr_nxt = ptr;
        wr_data_nxt = data_in;
        ptr_nxt     = ptr + 1'b1;
      end

      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            pre_q_nxt     = pre_len;
            ptr_nxt       = '0;
            count_nxt     = '0;
            post_cnt_nxt  = '0;
            triggered_nxt = 1'b0;
            state_nxt     = (pre_len == '0) ? ST_WAIT : ST_PRE;
          end
        end

        ST_PRE: begin
          if (sample_en) begin
            count_nxt = count_inc;
            if (count_inc == pre_q) begin
              state_nxt = ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (sample_en && hit) begin
            trig_addr_nxt = ptr;
            triggered_nxt = 1'b1;
            post_cnt_nxt  = post_init;
            if (post_init == '0) begin
              // Trigger sample is the last one; trig_addr is loading this
              // cycle, so derive the oldest address from ptr directly.
              state_nxt      = ST_DONE;
              start_addr_nxt = ptr - pre_q;
            end else begin
              state_nxt = ST_POST;
            end
          end
        end

        ST_POST: begin
          if (sample_en) begin
            post_cnt_nxt = post_cnt - 1'b1;
            if (post_cnt == ADDR_LEN'(1)) begin
              state_nxt      = ST_DONE;
              start_addr_nxt = trig_addr - pre_q;
            end
          end
        end

        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          abort;
  logic          sample_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] trig_value;
  logic [DW-1:0] trig_mask;
  logic [AW-1:0] pre_len;
  logic          wen;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] start_addr;

  int n_asserts = 0;
  int n_fail    = 0;
  int wcount    = 0;
  int base;
  int t_trig;
  int t_done;
  logic [DW-1:0] mem [DEPTH];

  capture_ctrl #(
    .DATA_LEN (DW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .abort      (abort),
    .sample_en  (sample_en),
    .data_in    (data_in),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .pre_len    (pre_len),
    .wen        (wen),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .trig_addr  (trig_addr),
    .start_addr (start_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample #1 after the edge and model the SRAM write.
  task automatic step();
    @(posedge clk);
    #1;
    if (wen === 1'b1) begin
      wcount++;
      mem[wr_addr] = wr_data;
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; sample_en = 1'b0;
    data_in = '0; trig_value = '0; trig_mask = '0; pre_len = '0;
    step(); step();
    check("rst_ctrl", {wen, busy, triggered, done}, 0);
    check("rst_addr", {wr_addr, trig_addr, start_addr}, 0);
    check("rst_data", wr_data, 0);
    rst = 1'b0;
    sample_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_hold", {wen, busy, done, start_addr}, 0);
    end

    // Normal capture: pre 4, trigger on 0x30.
    trig_mask = 8'hFF; trig_value = 8'h30; pre_len = 4'd4;
    arm = 1'b1; step(); arm = 1'b0;
    check("t1_busy", busy, 1);
    base = wcount; t_trig = -1; t_done = -1;
    for (int k = 0; k < 100; k++) begin
      data_in = 8'(k);
      step();
      if (wen && wr_data == 8'h30 && t_trig < 0) t_trig = k;
      if (done) begin t_done = k; break; end
    end
    check("t1_trig_sample", t_trig, 48);
    check("t1_done_lat", t_done - t_trig, 11);
    check("t1_trig_addr", trig_addr, 0);
    check("t1_start_addr", start_addr, 12);
    check("t1_flags", {triggered, busy}, 2'b10);
    check("t1_writes", wcount - base, 60);
    step();
    check("t1_no_wr_done", wen, 0);
    for (int i = 0; i < 16; i++) begin
      check("t1_mem", mem[(12 + i) % 16], 8'h2C + 8'(i));
    end

    // Trigger value during PRE is ignored; re-arm from DONE.
    trig_value = 8'hAA; pre_len = 4'd4; data_in = 8'h00;
    arm = 1'b1; step(); arm = 1'b0;
    check("t2_rearm", {done, busy, triggered}, 3'b010);
    t_done = -1;
    for (int k = 0; k < 100; k++) begin
      data_in = (k < 3 || k == 7) ? 8'hAA : 8'(k);
      step();
      if (done) begin t_done = k; break; end
    end
    check("t2_done_at", t_done, 18);
    check("t2_trig_addr", trig_addr, 7);
    check("t2_start_addr", start_addr, 3);

    // Zero mask, zero pre: immediate trigger, exactly DEPTH writes.
    trig_mask = 8'h00; pre_len = 4'd0;
    arm = 1'b1; step(); arm = 1'b0;
    check("t3_busy", busy, 1);
    base = wcount; t_done = -1;
    for (int k = 0; k < 100; k++) begin
      data_in = 8'(k + 64);
      step();
      if (k == 0) check("t3_imm_trig", {triggered, wr_addr}, {1'b1, 4'd0});
      if (done) begin t_done = k; break; end
    end
    check("t3_done_at", t_done, 15);
    check("t3_writes", wcount - base, 16);
    check("t3_addrs", {trig_addr, start_addr}, 0);

    // pre_len = DEPTH-1: done on the trigger write.
    trig_mask = 8'hFF; trig_value = 8'h14; pre_len = 4'd15;
    arm = 1'b1; step(); arm = 1'b0;
    base = wcount; t_done = -1;
    for (int k = 0; k < 100; k++) begin
      data_in = 8'(k);
      step();
      if (done) begin t_done = k; break; end
    end
    check("t4_done_at", t_done, 20);
    check("t4_last_wr", {wen, wr_data}, {1'b1, 8'h14});
    check("t4_trig_addr", trig_addr, 4);
    check("t4_start_addr", start_addr, 5);
    check("t4_writes", wcount - base, 21);

    // Abort in WAIT.
    trig_value = 8'hEE; pre_len = 4'd2;
    arm = 1'b1; step(); arm = 1'b0;
    for (int k = 0; k < 5; k++) begin
      data_in = 8'(k);
      step();
    end
    check("ab_in_wait", busy, 1);
    abort = 1'b1; data_in = 8'h05; step(); abort = 1'b0;
    check("ab_state", {busy, done, triggered, wen}, 0);
    step();
    check("ab_no_wr", wen, 0);
    arm = 1'b1; abort = 1'b1; step(); arm = 1'b0; abort = 1'b0;
    check("ab_wins_arm", busy, 0);

    // arm ignored in POST, sample_en gap holds counters.
    trig_value = 8'h08; pre_len = 4'd4;
    arm = 1'b1; step(); arm = 1'b0;
    for (int k = 0; k < 12; k++) begin
      data_in = 8'(k);
      step();
    end
    check("post_entered", {busy, triggered}, 2'b11);
    arm = 1'b1; data_in = 8'd12; step(); arm = 1'b0;
    check("post_arm_ign", {busy, triggered, wr_addr}, {1'b1, 1'b1, 4'd12});
    sample_en = 1'b0;
    base = wcount;
    for (int i = 0; i < 5; i++) begin
      step();
      check("gap_no_wr", wen, 0);
    end
    check("gap_writes", wcount - base, 0);
    check("gap_busy", busy, 1);
    sample_en = 1'b1; t_done = -1;
    for (int k = 13; k < 100; k++) begin
      data_in = 8'(k);
      step();
      if (done) begin t_done = k; break; end
    end
    check("gap_done_at", t_done, 19);
    check("gap_last_addr", wr_addr, 3);
    check("gap_addrs", {trig_addr, start_addr}, {4'd8, 4'd4});

    // Reset pulse mid-POST.
    trig_value = 8'h03; pre_len = 4'd1;
    arm = 1'b1; step(); arm = 1'b0;
    for (int k = 0; k < 6; k++) begin
      data_in = 8'(k);
      step();
    end
    check("rst_pre_cond", {busy, triggered, wen}, 3'b111);
    #1 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {wen, busy, triggered, done}, 0);
    check("rst_async_addr", {wr_addr, trig_addr, start_addr}, 0);
    check("rst_async_data", wr_data, 0);
    rst = 1'b0;
    step();
    check("rst_then_idle", {wen, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
